// File: rtl/alu_ctrl_pkg.sv
// ALU control codes shared with instruction decode, plus the mul/div unit state encoding.
package alu_ctrl_pkg;

  // Decode control codes (same values decode emits)
  localparam logic [5:0] AluAnd  = 6'b000000;
  localparam logic [5:0] AluOr   = 6'b000001;
  localparam logic [5:0] AluAdd  = 6'b000010;
  localparam logic [5:0] AluSub  = 6'b000011;
  localparam logic [5:0] AluSlt  = 6'b000100;
  localparam logic [5:0] AluDiv  = 6'b000101;
  localparam logic [5:0] AluDivu = 6'b000110;
  localparam logic [5:0] AluMfhi = 6'b001001;
  localparam logic [5:0] AluMflo = 6'b001010;
  localparam logic [5:0] AluMthi = 6'b001011;
  localparam logic [5:0] AluMtlo = 6'b001100;
  localparam logic [5:0] AluMult = 6'b001101;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } mdu_state_t;

endpackage

// File: rtl/mdu_iter_core.sv
// Iterative datapath: one shift-add (multiply) or one restore-subtract (divide) step per cycle
// on unsigned magnitudes. Multiply leaves the product in acc; divide leaves
// {remainder, quotient}.
module mdu_iter_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              clear,
  input  logic              div_mode,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic [2*XLEN-1:0] acc,
  output logic              last
);

  localparam int unsigned CntW = $clog2(XLEN);

  logic [2*XLEN-1:0] acc_q, acc_d, mul_next, div_next;
  logic [XLEN-1:0]   opnd_q;
  logic [CntW-1:0]   cnt_q;
  logic [XLEN:0]     sum, rem_sh;
  logic [XLEN-1:0]   diff;
  logic              ge;

  // Next accumulator value for both step kinds
  always_comb begin
    // Multiply: add multiplicand to the upper half when the current multiplier bit is set,
    // then shift the whole accumulator right (carry lands in the top bit).
    sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
    mul_next = acc_q[0] ? {sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    // Divide: shift left one, trial-subtract the divisor from the partial remainder.
    // The shifted remainder is below 2*divisor, so the difference fits in XLEN bits.
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    ge       = rem_sh >= {1'b0, opnd_q};
    diff     = rem_sh[XLEN-1:0] - opnd_q;
    div_next = {(ge ? diff : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], ge};
    acc_d    = div_mode ? div_next : mul_next;
  end

  // Operand load, iteration and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (load) begin
      // Multiply: low half holds the multiplier, opnd the multiplicand.
      // Divide: low half holds the dividend, opnd the divisor.
      acc_q  <= {{XLEN{1'b0}}, (div_mode ? op_a : op_b)};
      opnd_q <= div_mode ? op_b : op_a;
      cnt_q  <= '0;
    end else if (step) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + 1'b1;  // wraps to 0 on the final step
    end
  end

  assign acc  = acc_q;
  assign last = (cnt_q == CntW'(XLEN - 1));

endmodule

// File: rtl/hilo_muldiv_unit.sv
// EX-stage multiply/divide unit owning HI/LO. Handles the handshake, sign conversion around the
// unsigned iterative core, and the FSM IDLE -> MUL/DIV -> FIX -> IDLE.
module hilo_muldiv_unit
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid_i,
  input  logic [5:0]      alu_ctrl_i,
  input  logic            unsigned_i,
  input  logic [XLEN-1:0] rs_i,
  input  logic [XLEN-1:0] rt_i,
  input  logic            flush_i,
  output logic            op_ready_o,
  output logic            busy_o,
  output logic            rd_valid_o,
  output logic [XLEN-1:0] rd_data_o
);

  mdu_state_t state_q;
  logic [XLEN-1:0] hi_q, lo_q, rs_q;
  logic busy_q, op_div_q, neg_res_q, neg_rem_q, div_zero_q;

  logic is_mult, is_div, is_divu, is_mthi, is_mtlo, is_mfhi, is_mflo;
  logic accept, signed_op, start, core_div_mode, core_step, core_clear, core_last;
  logic [XLEN-1:0] rs_mag, rt_mag;
  logic [2*XLEN-1:0] core_acc, prod;
  logic [XLEN-1:0] quo, rem, fix_hi, fix_lo;

  // Decode and handshake
  always_comb begin
    is_mult    = (alu_ctrl_i == AluMult);
    is_div     = (alu_ctrl_i == AluDiv);
    is_divu    = (alu_ctrl_i == AluDivu);
    is_mthi    = (alu_ctrl_i == AluMthi);
    is_mtlo    = (alu_ctrl_i == AluMtlo);
    is_mfhi    = (alu_ctrl_i == AluMfhi);
    is_mflo    = (alu_ctrl_i == AluMflo);
    op_ready_o = (state_q == IDLE) & ~flush_i;
    accept     = op_valid_i & op_ready_o;
    rd_valid_o = accept & (is_mfhi | is_mflo);
    rd_data_o  = '0;
    if (rd_valid_o) rd_data_o = is_mfhi ? hi_q : lo_q;
  end

  // Operand magnitudes and core control
  always_comb begin
    signed_op     = is_mult ? ~unsigned_i : is_div;
    rs_mag        = (signed_op & rs_i[XLEN-1]) ? -rs_i : rs_i;
    rt_mag        = (signed_op & rt_i[XLEN-1]) ? -rt_i : rt_i;
    start         = accept & (is_mult | is_div | is_divu);
    core_div_mode = start ? (is_div | is_divu) : (state_q == DIV);
    core_step     = ((state_q == MUL) | (state_q == DIV)) & ~flush_i;
    core_clear    = flush_i & (state_q != IDLE);
  end

  mdu_iter_core #(
    .XLEN (XLEN)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (start),
    .step     (core_step),
    .clear    (core_clear),
    .div_mode (core_div_mode),
    .op_a     (rs_mag),
    .op_b     (rt_mag),
    .acc      (core_acc),
    .last     (core_last)
  );

  // Sign-corrected results, written to HI/LO in FIX
  always_comb begin
    prod   = neg_res_q ? -core_acc : core_acc;
    quo    = core_acc[XLEN-1:0];
    rem    = core_acc[2*XLEN-1:XLEN];
    fix_hi = prod[2*XLEN-1:XLEN];
    fix_lo = prod[XLEN-1:0];
    if (op_div_q) begin
      // Divide-by-zero result is architectural, not what the iteration produced
      fix_lo = div_zero_q ? '1 : (neg_res_q ? -quo : quo);
      fix_hi = div_zero_q ? rs_q : (neg_rem_q ? -rem : rem);
    end
  end

  // FSM, HI/LO and registered busy
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      rs_q       <= '0;
      op_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_mthi) hi_q <= rs_i;
            if (is_mtlo) lo_q <= rs_i;
            if (start) begin
              state_q    <= is_mult ? MUL : DIV;
              busy_q     <= 1'b1;
              op_div_q   <= ~is_mult;
              neg_res_q  <= signed_op & (rs_i[XLEN-1] ^ rt_i[XLEN-1]);
              neg_rem_q  <= signed_op & rs_i[XLEN-1];
              div_zero_q <= (rt_i == '0);
              rs_q       <= rs_i;
            end
          end
        end
        MUL, DIV: begin
          if (flush_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (core_last) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (!flush_i) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: vector table of long ops plus handshake/flush/reset cases.
module tb_hilo_muldiv_unit;
  import alu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, op_valid, unsigned_op, flush;
  logic [5:0]  alu_ctrl;
  logic [31:0] rs, rt;
  logic        op_ready, busy, rd_valid;
  logic [31:0] rd_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [5:0]  ctrl;
    logic        uns;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  hilo_muldiv_unit #(
    .XLEN (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid_i (op_valid),
    .alu_ctrl_i (alu_ctrl),
    .unsigned_i (unsigned_op),
    .rs_i       (rs),
    .rt_i       (rt),
    .flush_i    (flush),
    .op_ready_o (op_ready),
    .busy_o     (busy),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present an op before edge E0; returns just after E0 with inputs released
  task automatic issue(input logic [5:0] ctrl, input logic uns, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    op_valid = 1'b1; alu_ctrl = ctrl; unsigned_op = uns; rs = a; rt = b;
    #1;
    check("issue_ready", {63'd0, op_ready}, 64'd1);
    @(posedge clk);
    #1;
    op_valid = 1'b0; alu_ctrl = 6'd0; unsigned_op = 1'b0; rs = '0; rt = '0;
  endtask

  task automatic read_reg(input string name, input logic [5:0] ctrl, input logic [31:0] exp);
    @(negedge clk);
    op_valid = 1'b1; alu_ctrl = ctrl;
    #1;
    check({name, "_valid"}, {63'd0, rd_valid}, 64'd1);
    check(name, {32'd0, rd_data}, {32'd0, exp});
    op_valid = 1'b0; alu_ctrl = 6'd0;
  endtask

  // Counts busy cycles after issue, bounded
  task automatic wait_done(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!busy) break;
      n++;
      if (n > 100) begin
        check("busy_timeout", 64'd1, 64'd0);
        break;
      end
    end
    check("ready_after_done", {63'd0, op_ready}, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0]  = '{"mult_m2x3",     AluMult, 1'b0, 32'hFFFFFFFE, 32'd3,       32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{"multu_m2x3",    AluMult, 1'b1, 32'hFFFFFFFE, 32'd3,       32'h00000002, 32'hFFFFFFFA};
    vecs[2]  = '{"div_m7_2",      AluDiv,  1'b0, 32'hFFFFFFF9, 32'd2,       32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{"divu_7_0",      AluDivu, 1'b0, 32'd7,        32'd0,       32'h00000007, 32'hFFFFFFFF};
    vecs[4]  = '{"div_ovf",       AluDiv,  1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{"div_m5_0",      AluDiv,  1'b0, 32'hFFFFFFFB, 32'd0,       32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[6]  = '{"multu_max",     AluMult, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[7]  = '{"mult_min_min",  AluMult, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8]  = '{"div_100_m7",    AluDiv,  1'b0, 32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2};
    vecs[9]  = '{"divu_big_2",    AluDivu, 1'b0, 32'hFFFFFFF9, 32'd2,       32'h00000001, 32'h7FFFFFFC};
    vecs[10] = '{"mult_pos",      AluMult, 1'b0, 32'h12345678, 32'h100,     32'h00000012, 32'h34567800};
    vecs[11] = '{"div_uns_ignored", AluDiv, 1'b1, 32'hFFFFFFF9, 32'd2,      32'hFFFFFFFF, 32'hFFFFFFFD};

    rst = 1'b1; op_valid = 1'b0; alu_ctrl = 6'd0; unsigned_op = 1'b0; rs = '0; rt = '0;
    flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_ready", {63'd0, op_ready}, 64'd1);
    check("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    check("rst_rd_data", {32'd0, rd_data}, 64'd0);
    rst = 1'b0;
    read_reg("rst_hi", AluMfhi, 32'd0);
    read_reg("rst_lo", AluMflo, 32'd0);

    // mthi/mtlo visible to the next cycle's mfhi/mflo
    issue(AluMthi, 1'b0, 32'hCAFEF00D, 32'd0);
    read_reg("mthi_hi", AluMfhi, 32'hCAFEF00D);
    issue(AluMtlo, 1'b0, 32'h0BADBEEF, 32'd0);
    read_reg("mtlo_lo", AluMflo, 32'h0BADBEEF);
    read_reg("mtlo_hi_kept", AluMfhi, 32'hCAFEF00D);

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].ctrl, vecs[i].uns, vecs[i].a, vecs[i].b);
      wait_done(n);
      check({vecs[i].name, "_busy_cycles"}, 64'(n), 64'd33);
      read_reg({vecs[i].name, "_hi"}, AluMfhi, vecs[i].exp_hi);
      read_reg({vecs[i].name, "_lo"}, AluMflo, vecs[i].exp_lo);
    end

    // Unused code is a no-op
    issue(6'b111111, 1'b0, 32'h55555555, 32'h1);
    @(negedge clk);
    #1;
    check("noop_busy", {63'd0, busy}, 64'd0);
    read_reg("noop_hi", AluMfhi, 32'hFFFFFFFF);
    read_reg("noop_lo", AluMflo, 32'hFFFFFFFD);

    // mflo held from E0+5 stalls until E0+34, then returns the new LO
    issue(AluMult, 1'b0, 32'd5, 32'd6);
    repeat (4) @(negedge clk);
    @(negedge clk);
    op_valid = 1'b1; alu_ctrl = AluMflo;
    n = 0;
    forever begin
      #1;
      if (op_ready || n > 100) break;
      n++;
      @(negedge clk);
    end
    check("stall_cycles", 64'(n), 64'd29);
    check("stall_rd_valid", {63'd0, rd_valid}, 64'd1);
    check("stall_rd_data", {32'd0, rd_data}, 64'd30);
    op_valid = 1'b0; alu_ctrl = 6'd0;

    // Flush at iteration 20 leaves HI/LO untouched
    issue(AluMthi, 1'b0, 32'h12345678, 32'd0);
    issue(AluMtlo, 1'b0, 32'h0BADF00D, 32'd0);
    issue(AluMult, 1'b1, 32'h00010000, 32'h00010000);
    repeat (21) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_busy_before", {63'd0, busy}, 64'd1);
    check("flush_ready_low", {63'd0, op_ready}, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_ready_after", {63'd0, op_ready}, 64'd1);
    check("flush_busy_after", {63'd0, busy}, 64'd0);
    read_reg("flush_hi", AluMfhi, 32'h12345678);
    read_reg("flush_lo", AluMflo, 32'h0BADF00D);

    // Flush landing in FIX also discards the result
    issue(AluMult, 1'b1, 32'h00010000, 32'h00010000);
    repeat (33) @(negedge clk);
    #1;
    check("fix_busy", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("fix_flush_busy", {63'd0, busy}, 64'd0);
    read_reg("fix_flush_hi", AluMfhi, 32'h12345678);
    read_reg("fix_flush_lo", AluMflo, 32'h0BADF00D);

    // Flush in IDLE blocks acceptance
    @(negedge clk);
    op_valid = 1'b1; alu_ctrl = AluMthi; rs = 32'hDEADDEAD; flush = 1'b1;
    #1;
    check("idle_flush_ready", {63'd0, op_ready}, 64'd0);
    @(negedge clk);
    op_valid = 1'b0; alu_ctrl = 6'd0; rs = '0; flush = 1'b0;
    read_reg("idle_flush_hi", AluMfhi, 32'h12345678);

    // Reset mid-divide at iteration 10
    issue(AluDivu, 1'b0, 32'd100, 32'd7);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_ready", {63'd0, op_ready}, 64'd1);
    read_reg("midrst_hi", AluMfhi, 32'd0);
    read_reg("midrst_lo", AluMflo, 32'd0);

    // Unit still works after the mid-op reset
    issue(AluDivu, 1'b0, 32'd100, 32'd7);
    wait_done(n);
    check("post_rst_busy_cycles", 64'(n), 64'd33);
    read_reg("post_rst_hi", AluMfhi, 32'd2);
    read_reg("post_rst_lo", AluMflo, 32'd14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Multi-cycle multiply/divide unit with the architectural HI/LO register pair, sitting in the EX stage as the consumer of the 6-bit ALU control code produced by instruction decode. It executes mult, multu, div, divu, mthi, mtlo, mfhi and mflo. It holds the pipeline through a ready/valid handshake while an iterative operation is in flight.

## Interface
- `XLEN`, default 32: operand and HI/LO width. Only 32 is supported.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `op_valid_i` input 1: EX presents an operation this cycle.
- `alu_ctrl_i` input 6: decode code. 001101 mult/multu, 000101 div, 000110 divu, 001011 mthi, 001100 mtlo, 001001 mfhi, 001010 mflo. Any other code is a no-op.
- `unsigned_i` input 1: selects multu when `alu_ctrl_i`=001101. Ignored for all other codes.
- `rs_i` input 32: multiplicand/dividend; also the mthi/mtlo source.
- `rt_i` input 32: multiplier/divisor.
- `flush_i` input 1: kill the in-flight operation.
- `op_ready_o` output 1: the unit accepts `op_valid_i` this cycle.
- `busy_o` output 1: an iterative operation is in flight.
- `rd_valid_o` output 1: `rd_data_o` is valid for an accepted mfhi/mflo.
- `rd_data_o` output 32: HI or LO read data.

## Operation
- An operation is accepted when `op_valid_i & op_ready_o`. `op_ready_o` = (state==IDLE) & ~flush_i.
- Accepted mthi/mtlo: HI/LO is written with `rs_i` at the next edge.
- Accepted mfhi/mflo: `rd_data_o` is driven combinationally from the current HI/LO and `rd_valid_o`=1 in the same cycle.
- Accepted mult/div: operands are latched and the state moves to MUL or DIV.
- Accepted no-op code: no state change.
- Signed ops operate on the magnitudes.
  - Product sign = sign(rs) xor sign(rt).
  - Quotient sign = sign(rs) xor sign(rt).
  - Remainder sign = sign(rs).
- Multiply: radix-2 shift-add over a 64-bit accumulator. Result {HI,LO} = 64-bit product.
- Divide: restoring, one quotient bit per cycle. Result LO = quotient, HI = remainder.
- Division by zero: HI = rs_i, LO = 0xFFFFFFFF for both signed and unsigned. The iteration still runs full length.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO = 0x80000000, HI = 0. This falls out of magnitude arithmetic and is not special-cased.
- State machine:
  - IDLE → MUL or DIV on acceptance.
  - MUL or DIV → FIX after 32 iteration cycles.
  - FIX → IDLE, with HI/LO written at the FIX edge.
  - `flush_i` in MUL, DIV or FIX → IDLE at the next edge. HI/LO are unchanged.
- `flush_i` with `op_valid_i` in IDLE: the op is not accepted (`op_ready_o`=0).

## Timing
- Reset values: state IDLE, HI=0, LO=0, iteration counter 0, `busy_o`=0, `op_ready_o`=1 (if `flush_i`=0), `rd_valid_o`=0, `rd_data_o`=0.
- Reset takes priority over every other input, including mid-operation. The in-flight op is discarded.
- mult/div accepted at edge E0:
  - `busy_o`=1 for cycles E0+1 … E0+33.
  - HI/LO hold new values from E0+34.
  - `op_ready_o` returns to 1 in cycle E0+34.
  - Total latency is 34 cycles.
- mthi/mtlo accepted at edge E0: the new value is visible to mfhi in cycle E0+1.
- No write-through: mfhi in the same cycle as an accepted mthi is impossible, since only one op is accepted per cycle.
- `busy_o` = (state != IDLE), registered. `op_ready_o` and `rd_*` are combinational.
- Counter: 5 bits, counts 0..31 and wraps to 0 on exit to FIX.

## Structure
- Shared package `alu_ctrl_pkg` holds:
  - the 6-bit ALU control code localparams, including the seven used here; these are the same values decode emits;
  - the state enum `mdu_state_t` {IDLE, MUL, DIV, FIX}.
- One sub-module, `mdu_iter_core`:
  - contains the 64-bit accumulator, 32-bit operand register and 5-bit counter;
  - performs one shift-add or one restore-subtract step per cycle under a mode bit.
- The top level owns the FSM, sign handling, HI/LO and the handshake.

## Test plan
- Reset mid-DIV at iteration 10 → state IDLE, `busy_o`=0 next cycle, HI=LO=0.
- mult rs=0xFFFFFFFE (−2), rt=3, `unsigned_i`=0 → after 34 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div rs=−7 (0xFFFFFFF9), rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 → LO=0xFFFFFFFF, HI=7.
- div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- mflo presented at cycle E0+5 of a mult → `op_ready_o`=0 until E0+34, then `rd_data_o` = new LO with `rd_valid_o`=1.
- mthi 0x12345678, then mult flushed at iteration 20 → HI stays 0x12345678, `op_ready_o`=1 the cycle after the flush edge.
